// File: rtl/tree_accumulator_if.sv
// Job/beat/result handshake bundle for tree_accumulator.
// master drives jobs and beats; slave is the accumulator.
interface tree_accumulator_if #(
  parameter int IN_DATAW  = 10,
  parameter int ACC_DATAW = 32,
  parameter int CNT_W     = 8
);
  logic                 start_i;
  logic [CNT_W-1:0]     len_i;
  logic                 signed_i;
  logic [IN_DATAW-1:0]  in_data_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [ACC_DATAW-1:0] out_data_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 busy_o;

  modport master (
    output start_i,
    output len_i,
    output signed_i,
    output in_data_i,
    output in_valid_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_data_o,
    input  out_valid_o,
    input  busy_o
  );

  modport slave (
    input  start_i,
    input  len_i,
    input  signed_i,
    input  in_data_i,
    input  in_valid_i,
    input  out_ready_i,
    output in_ready_o,
    output out_data_o,
    output out_valid_o,
    output busy_o
  );
endinterface

// File: rtl/tree_accumulator.sv
// Sums len beats of adder-tree partial sums into one
// wrapping ACC_DATAW result, then holds it for handshake.
module tree_accumulator #(
  parameter int IN_DATAW  = 10,
  parameter int ACC_DATAW = 32,
  parameter int CNT_W     = 8
) (
  input logic clk_i,
  input logic rst_ni,
  tree_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

  state_t state_q, state_d;

  logic [ACC_DATAW-1:0] acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     len_q;
  logic                 sgn_q;

  logic [IN_DATAW-1:0]  din;
  logic [ACC_DATAW-1:0] ext;
  logic                 take;
  logic                 last;
  logic                 go;

  assign din  = bus.in_data_i;
  assign take = bus.in_valid_i && (state_q == ACC);
  assign last = (cnt_q == len_q - CNT_W'(1));
  assign go   = bus.start_i && (state_q == IDLE);

  // size cast keeps signedness, so $signed() sign-extends
  always_comb begin
    ext = ACC_DATAW'(din);
    if (sgn_q) ext = ACC_DATAW'($signed(din));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.len_i == '0) state_d = OUT;
          else                 state_d = ACC;
        end
      end
      ACC: begin
        if (take && last) state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (go) begin
        acc_q <= '0;
        cnt_q <= '0;
        len_q <= bus.len_i;
        sgn_q <= bus.signed_i;
      end else if (take) begin
        acc_q <= acc_q + ext;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready_o  = (state_q == ACC);
  assign bus.out_valid_o = (state_q == OUT);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.out_data_o  = acc_q;

endmodule
